// File: rtl/nco_pkg.sv
// nco_pkg: shared types for the multi-channel NCO.
//   cfg_field_e - selects which per-channel register a config write targets
//   wave_mode_e - phase-to-amplitude shape of one channel
package nco_pkg;

  typedef enum logic [1:0] {
    FREQ      = 2'd0,
    PHASE_OFS = 2'd1,
    MODE      = 2'd2,
    DUTY      = 2'd3
  } cfg_field_e;

  typedef enum logic [1:0] {
    SQUARE = 2'd0,
    SAW    = 2'd1,
    TRI    = 2'd2,
    PULSE  = 2'd3
  } wave_mode_e;

endpackage

// File: rtl/nco_wave_gen.sv
// nco_wave_gen: combinational phase-to-amplitude mapping for one channel.
//   t    - truncated phase (top OUT_W bits of the accumulator+offset)
//   mode - waveform shape
//   duty - pulse threshold, used in PULSE mode only
//   amp  - unsigned amplitude
module nco_wave_gen
  import nco_pkg::*;
#(
  parameter int unsigned OUT_W = 8
) (
  input  logic [OUT_W-1:0] t,
  input  wave_mode_e       mode,
  input  logic [OUT_W-1:0] duty,
  output logic [OUT_W-1:0] amp
);

  logic [OUT_W-1:0] s;

  always_comb begin
    // Triangle: ramp up on the first half period, mirrored ramp on the second.
    s   = t << 1;
    amp = '0;
    case (mode)
      SQUARE:  amp = t[OUT_W-1] ? '1 : '0;
      SAW:     amp = t;
      TRI:     amp = t[OUT_W-1] ? ~s : s;
      PULSE:   amp = (t < duty) ? '1 : '0;
      default: amp = '0;
    endcase
  end

endmodule

// File: rtl/nco_multi.sv
// nco_multi: NUM_CH independent phase accumulators with shadowed frequency
// words, phase offsets and selectable waveforms, plus a registered mixer.
//   clk, rst   - clock, asynchronous active-high reset
//   ch_en      - per-channel enable
//   sync_i     - zero all accumulators, commit pending frequency words
//   cfg_*      - valid/ready config write port (channel, field, data)
//   wave_o     - per-channel amplitude, channel 0 in the LSBs
//   wrap_o     - one-cycle accumulator wrap strobe, aligned with wave_o
//   mix_o      - registered unsigned sum of enabled channels' wave_o
module nco_multi
  import nco_pkg::*;
#(
  parameter  int unsigned NUM_CH = 4,
  parameter  int unsigned ACC_W  = 16,
  parameter  int unsigned OUT_W  = 8,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned MIX_W  = OUT_W + $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic                    sync_i,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [1:0]              cfg_field,
  input  logic [ACC_W-1:0]        cfg_data,
  output logic [NUM_CH*OUT_W-1:0] wave_o,
  output logic [NUM_CH-1:0]       wrap_o,
  output logic [MIX_W-1:0]        mix_o
);

  localparam logic [OUT_W-1:0] DUTY_RST = OUT_W'(1) << (OUT_W - 1);

  logic [ACC_W-1:0] acc     [NUM_CH];
  logic [ACC_W-1:0] freq    [NUM_CH];
  logic [ACC_W-1:0] freq_sh [NUM_CH];
  logic [ACC_W-1:0] ofs     [NUM_CH];
  logic [ACC_W-1:0] phase   [NUM_CH];
  logic [ACC_W:0]   sum_ext [NUM_CH];
  wave_mode_e       mode    [NUM_CH];
  logic [OUT_W-1:0] duty    [NUM_CH];
  logic [OUT_W-1:0] amp     [NUM_CH];
  logic [OUT_W-1:0] wave    [NUM_CH];

  logic [NUM_CH-1:0] pend, carry, carry_q;
  logic [NUM_CH-1:0] wr_freq, wr_ofs, wr_mode, wr_duty;
  logic              pend_sel, accept;
  cfg_field_e        field;
  logic [MIX_W-1:0]  mix_next;

  // Only a FREQ write to a channel whose previous FREQ write is still
  // waiting for its wrap is back-pressured; out-of-range channels never stall.
  always_comb begin
    field    = cfg_field_e'(cfg_field);
    pend_sel = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) pend_sel = pend[i];
    end
    cfg_ready = !(field == FREQ && pend_sel);
    accept    = cfg_valid && cfg_ready;
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sum_ext[i] = {1'b0, acc[i]} + {1'b0, freq[i]};
      carry[i]   = ch_en[i] && sum_ext[i][ACC_W];
      phase[i]   = acc[i] + ofs[i];
      wr_freq[i] = accept && cfg_ch == CH_W'(i) && field == FREQ;
      wr_ofs[i]  = accept && cfg_ch == CH_W'(i) && field == PHASE_OFS;
      wr_mode[i] = accept && cfg_ch == CH_W'(i) && field == MODE;
      wr_duty[i] = accept && cfg_ch == CH_W'(i) && field == DUTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        acc[i]     <= '0;
        freq[i]    <= '0;
        freq_sh[i] <= '0;
        ofs[i]     <= '0;
        mode[i]    <= SQUARE;
        duty[i]    <= DUTY_RST;
        wave[i]    <= '0;
      end
      pend    <= '0;
      carry_q <= '0;
      wrap_o  <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (sync_i)        acc[i] <= '0;
        else if (ch_en[i]) acc[i] <= sum_ext[i][ACC_W-1:0];

        // Carry is delayed one extra stage so the strobe lines up with the
        // amplitude of the wrapped accumulator value.
        carry_q[i] <= carry[i] && !sync_i;
        wrap_o[i]  <= carry_q[i] && ch_en[i];
        wave[i]    <= ch_en[i] ? amp[i] : '0;

        // A write landing on a carry cycle only arms pend; pend is 0 whenever
        // a write is accepted, so it cannot commit on that same carry.
        if (wr_freq[i]) begin
          freq_sh[i] <= cfg_data;
          if (!ch_en[i] || sync_i) begin
            freq[i] <= cfg_data;
            pend[i] <= 1'b0;
          end else begin
            pend[i] <= 1'b1;
          end
        end else if (pend[i] && (!ch_en[i] || sync_i || carry[i])) begin
          freq[i] <= freq_sh[i];
          pend[i] <= 1'b0;
        end

        if (wr_ofs[i])  ofs[i]  <= cfg_data;
        if (wr_mode[i]) mode[i] <= wave_mode_e'(cfg_data[1:0]);
        if (wr_duty[i]) duty[i] <= cfg_data[OUT_W-1:0];
      end
    end
  end

  always_comb begin
    mix_next = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_en[i]) mix_next = mix_next + MIX_W'(wave[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mix_o <= '0;
    else     mix_o <= mix_next;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    nco_wave_gen #(.OUT_W(OUT_W)) u_gen (
      .t    (phase[g][ACC_W-1 -: OUT_W]),
      .mode (mode[g]),
      .duty (duty[g]),
      .amp  (amp[g])
    );
    assign wave_o[g*OUT_W +: OUT_W] = wave[g];
  end

endmodule

// File: tb/tb_nco_multi.sv
module tb_nco_multi;
  import nco_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ch_en;
  logic        sync_i;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_ch;
  logic [1:0]  cfg_field;
  logic [15:0] cfg_data;
  logic [31:0] wave_o;
  logic [3:0]  wrap_o;
  logic [9:0]  mix_o;

  int n_checks = 0;
  int n_err    = 0;

  nco_multi #(.NUM_CH(4), .ACC_W(16), .OUT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .ch_en     (ch_en),
    .sync_i    (sync_i),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_field (cfg_field),
    .cfg_data  (cfg_data),
    .wave_o    (wave_o),
    .wrap_o    (wrap_o),
    .mix_o     (mix_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] wave;
    logic       wrap;
    logic [9:0] mix;
  } saw_vec_t;

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  duty;
    logic [15:0] ofs;
    logic [7:0]  exp;
  } wave_vec_t;

  saw_vec_t  st[34];
  wave_vec_t wt[15];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [1:0] f, input logic [15:0] d);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_field = f;
    cfg_data  = d;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    ch_en     = '0;
    sync_i    = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_field = FREQ;
    cfg_data  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stalls;

    // Saw sweep on ch0, FREQ=0x1000: wave steps 0x10/cycle, wrap every 16.
    for (int k = 1; k <= 34; k++) begin
      st[k-1].wave = 8'((k - 1) * 16);
      st[k-1].wrap = (k > 1) && ((k - 1) % 16 == 0);
      st[k-1].mix  = (k >= 2) ? 10'(((k - 2) % 16) * 16) : 10'd0;
    end

    // {mode, duty, ofs, expected amplitude} with freq=0 so t = ofs[15:8].
    wt[0]  = '{2'd1, 8'h80, 16'h1234, 8'h12};
    wt[1]  = '{2'd0, 8'h80, 16'h7F00, 8'h00};
    wt[2]  = '{2'd0, 8'h80, 16'h8000, 8'hFF};
    wt[3]  = '{2'd2, 8'h80, 16'h4000, 8'h80};
    wt[4]  = '{2'd2, 8'h80, 16'hC000, 8'h7F};
    wt[5]  = '{2'd2, 8'h80, 16'h0000, 8'h00};
    wt[6]  = '{2'd2, 8'h80, 16'h8000, 8'hFF};
    wt[7]  = '{2'd2, 8'h80, 16'h2100, 8'h42};
    wt[8]  = '{2'd3, 8'h40, 16'h3F00, 8'hFF};
    wt[9]  = '{2'd3, 8'h40, 16'h4000, 8'h00};
    wt[10] = '{2'd3, 8'h00, 16'h0000, 8'h00};
    wt[11] = '{2'd3, 8'hFF, 16'hFE00, 8'hFF};
    wt[12] = '{2'd3, 8'hFF, 16'hFF00, 8'h00};
    wt[13] = '{2'd1, 8'h80, 16'hFFFF, 8'hFF};
    wt[14] = '{2'd2, 8'h80, 16'hE000, 8'h3F};

    // Reset state and reset duty value.
    do_reset();
    chk("reset wave", wave_o, 32'h0);
    chk("reset wrap", wrap_o, 4'h0);
    chk("reset mix", mix_o, 10'h0);
    chk("reset ready", cfg_ready, 1'b1);
    ch_en = 4'b0001;
    wr(2'd0, MODE, 16'h0003);
    tick();
    chk("duty reset pulse t=0", wave_o[7:0], 8'hFF);
    tick();
    chk("duty reset mix", mix_o, 10'h0FF);
    wr(2'd0, PHASE_OFS, 16'h8000);
    tick();
    chk("duty reset pulse t=80", wave_o[7:0], 8'h00);

    // Saw sweep table.
    do_reset();
    wr(2'd0, FREQ, 16'h1000);
    wr(2'd0, MODE, 16'h0001);
    ch_en = 4'b0001;
    for (int k = 0; k < 34; k++) begin
      tick();
      chk($sformatf("saw wave[%0d]", k), wave_o[7:0], st[k].wave);
      chk($sformatf("saw wrap[%0d]", k), wrap_o[0], st[k].wrap);
      chk($sformatf("saw mix[%0d]", k), mix_o, st[k].mix);
    end

    // Shadowed FREQ: pend back-pressure and commit on wrap.
    do_reset();
    wr(2'd0, FREQ, 16'h1000);
    wr(2'd0, MODE, 16'h0001);
    ch_en = 4'b0001;
    repeat (8) tick();
    chk("pre-write wave", wave_o[7:0], 8'h70);
    cfg_ch = 2'd0; cfg_field = FREQ; cfg_data = 16'h2000; cfg_valid = 1'b1;
    #1 chk("ready first ch0 freq", cfg_ready, 1'b1);
    tick();
    cfg_valid = 1'b0;
    #1 chk("ready ch0 freq pending", cfg_ready, 1'b0);
    cfg_field = PHASE_OFS;
    #1 chk("ready ch0 ofs while pending", cfg_ready, 1'b1);
    cfg_ch = 2'd1; cfg_field = FREQ; cfg_data = 16'h0100; cfg_valid = 1'b1;
    #1 chk("ready ch1 freq while ch0 pending", cfg_ready, 1'b1);
    tick();
    cfg_ch = 2'd0; cfg_field = FREQ; cfg_data = 16'h3000; cfg_valid = 1'b1;
    stalls = 0;
    #1;
    while (!cfg_ready && stalls < 20) begin
      tick();
      stalls++;
    end
    chk("second freq stall cycles", stalls, 6);
    tick();
    cfg_valid = 1'b0;
    chk("wrap at commit", wrap_o[0], 1'b1);
    chk("wave at commit", wave_o[7:0], 8'h00);
    tick();
    chk("new step 1", wave_o[7:0], 8'h20);
    tick();
    chk("new step 2", wave_o[7:0], 8'h40);
    cfg_field = FREQ; cfg_ch = 2'd0;
    #1 chk("ready third write pending", cfg_ready, 1'b0);

    // Waveform table on ch1.
    do_reset();
    ch_en = 4'b0010;
    for (int i = 0; i < 15; i++) begin
      wr(2'd1, MODE, {14'h0, wt[i].mode});
      wr(2'd1, DUTY, {8'h0, wt[i].duty});
      wr(2'd1, PHASE_OFS, wt[i].ofs);
      tick();
      chk($sformatf("wave_tbl[%0d]", i), wave_o[15:8], wt[i].exp);
    end

    // Mixer, channel disable and sync.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      wr(2'(c), FREQ, 16'h1000);
      wr(2'(c), MODE, 16'h0001);
    end
    ch_en = 4'hF;
    repeat (16) tick();
    chk("mix all wave", wave_o, 32'hF0F0_F0F0);
    tick();
    chk("mix 4x max", mix_o, 10'h3C0);
    chk("mix all wrap", wrap_o, 4'hF);
    ch_en = 4'hB;
    repeat (3) tick();
    chk("ch2 disabled wave", wave_o[23:16], 8'h00);
    chk("ch0 wave after disable", wave_o[7:0], 8'h30);
    chk("mix 3x", mix_o, 10'h060);
    repeat (11) tick();
    sync_i = 1'b1;
    tick();
    sync_i = 1'b0;
    chk("sync edge wrap", wrap_o, 4'h0);
    tick();
    chk("sync wave zero", wave_o, 32'h0);
    chk("sync no wrap", wrap_o, 4'h0);
    tick();
    chk("post sync wave", wave_o[7:0], 8'h10);

    // Asynchronous reset with a pending FREQ write.
    do_reset();
    wr(2'd0, FREQ, 16'h1000);
    wr(2'd0, MODE, 16'h0001);
    ch_en = 4'b0001;
    repeat (3) tick();
    wr(2'd0, FREQ, 16'h2000);
    cfg_field = FREQ; cfg_ch = 2'd0;
    #1 chk("pend before rst", cfg_ready, 1'b0);
    rst = 1'b1;
    #1;
    chk("async rst ready", cfg_ready, 1'b1);
    chk("async rst wave", wave_o, 32'h0);
    chk("async rst mix", mix_o, 10'h0);
    chk("async rst wrap", wrap_o, 4'h0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("post rst freq cleared wave", wave_o, 32'h0);
    chk("post rst ready", cfg_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
